// File: rtl/huffman_encoder.sv
`default_nettype none
// ============================================================================
// Module      : huffman_encoder
// Description : JPEG entropy encoder. Maps (run,size,amplitude) symbols to
//               Huffman code + amplitude bits, packs them MSB-first into
//               bytes, stuffs 0x00 after 0xFF and pads the last byte with 1s.
// Revision    : 1.0 - initial release
// ============================================================================
module huffman_encoder #(
    parameter int ACC_W    = 40,
    parameter bit STUFF_EN = 1'b1,
    parameter int H        = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [H-1:0][27:0] code_table,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         in_run,
    input  logic [3:0]         in_size,
    input  logic [15:0]        in_amp,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [7:0]         out_byte,
    output logic               done,
    output logic               err
);

    typedef enum logic [2:0] {
        S_ACCEPT = 3'd0,
        S_DRAIN  = 3'd1,
        S_STUFF  = 3'd2,
        S_PAD    = 3'd3,
        S_FINAL  = 3'd4
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [ACC_W-1:0] r_acc, w_acc_nxt;
    logic [5:0]       r_bit_cnt, w_bit_cnt_nxt;
    logic             r_last_pending, w_last_nxt;
    logic             r_err, w_err_nxt;

    logic             w_hit;
    logic [3:0]       w_code_len;
    logic [15:0]      w_code;
    logic [31:0]      w_code_bits, w_amp_bits, w_sym_bits;
    logic [5:0]       w_sym_len, w_cnt_after_byte;
    logic [7:0]       w_shamt, w_head;
    logic [ACC_W-1:0] w_append, w_pad_mask;

    // After a byte (or stuff byte) leaves: keep draining, pad, or accept more.
    function automatic state_t post_byte(input logic [5:0] cnt, input logic last);
        if (cnt >= 6'd8)
            return S_DRAIN;
        else if (last)
            return S_PAD;
        else
            return S_ACCEPT;
    endfunction

    // Table search: scan from the top so the lowest matching index wins.
    always_comb begin
        w_hit      = 1'b0;
        w_code_len = 4'd0;
        w_code     = 16'd0;
        for (int i = H - 1; i >= 0; i--) begin
            if (code_table[i][27:24] != 4'd0 && code_table[i][7:0] == {in_run, in_size}) begin
                w_hit      = 1'b1;
                w_code_len = code_table[i][27:24];
                w_code     = code_table[i][23:8];
            end
        end
    end

    // Concatenated code+amplitude bits, right-aligned, then placed just below
    // the bits already held at the top of the accumulator.
    assign w_code_bits      = {16'd0, w_code} & ((32'd1 << w_code_len) - 32'd1);
    assign w_amp_bits       = {16'd0, in_amp} & ((32'd1 << in_size) - 32'd1);
    assign w_sym_bits       = (w_code_bits << in_size) | w_amp_bits;
    assign w_sym_len        = {2'b00, w_code_len} + {2'b00, in_size};
    assign w_shamt          = 8'(ACC_W) - {2'b00, r_bit_cnt} - {2'b00, w_sym_len};
    assign w_append         = {{(ACC_W-32){1'b0}}, w_sym_bits} << w_shamt;
    assign w_pad_mask       = {8'hFF >> r_bit_cnt[2:0], {(ACC_W-8){1'b0}}};
    assign w_head           = r_acc[ACC_W-1 -: 8];
    assign w_cnt_after_byte = r_bit_cnt - 6'd8;
    assign err              = r_err;

    // Next-state, datapath updates and handshake outputs.
    always_comb begin
        w_state_nxt   = r_state;
        w_acc_nxt     = r_acc;
        w_bit_cnt_nxt = r_bit_cnt;
        w_last_nxt    = r_last_pending;
        w_err_nxt     = r_err;
        in_ready      = 1'b0;
        out_valid     = 1'b0;
        out_byte      = 8'h00;
        done          = 1'b0;
        case (r_state)
            S_ACCEPT: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (w_hit) begin
                        w_acc_nxt     = r_acc | w_append;
                        w_bit_cnt_nxt = r_bit_cnt + w_sym_len;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                    w_last_nxt = in_last;
                    if (w_bit_cnt_nxt >= 6'd8)
                        w_state_nxt = S_DRAIN;
                    else if (in_last)
                        w_state_nxt = S_PAD;
                end
            end
            S_DRAIN, S_FINAL: begin
                out_valid = 1'b1;
                out_byte  = w_head;
                if (out_ready) begin
                    w_acc_nxt     = r_acc << 8;
                    w_bit_cnt_nxt = w_cnt_after_byte;
                    if (STUFF_EN && w_head == 8'hFF) begin
                        w_state_nxt = S_STUFF;
                    end else if (r_state == S_FINAL) begin
                        done        = 1'b1;
                        w_last_nxt  = 1'b0;
                        w_state_nxt = S_ACCEPT;
                    end else begin
                        w_state_nxt = post_byte(w_cnt_after_byte, r_last_pending);
                    end
                end
            end
            S_STUFF: begin
                out_valid = 1'b1;
                if (out_ready)
                    w_state_nxt = post_byte(r_bit_cnt, r_last_pending);
            end
            S_PAD: begin
                if (r_bit_cnt == 6'd0) begin
                    done        = 1'b1;
                    w_last_nxt  = 1'b0;
                    w_state_nxt = S_ACCEPT;
                end else begin
                    w_acc_nxt     = r_acc | w_pad_mask;
                    w_bit_cnt_nxt = 6'd8;
                    w_state_nxt   = S_FINAL;
                end
            end
            default: w_state_nxt = S_ACCEPT;
        endcase
    end

    // State and datapath registers; reset drops any buffered bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_ACCEPT;
            r_acc          <= '0;
            r_bit_cnt      <= 6'd0;
            r_last_pending <= 1'b0;
            r_err          <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_acc          <= w_acc_nxt;
            r_bit_cnt      <= w_bit_cnt_nxt;
            r_last_pending <= w_last_nxt;
            r_err          <= w_err_nxt;
        end
    end

endmodule
`default_nettype wire
